mem_port_arbiter: RTL and testbench

- Shares one bus of synth_dual_port_memory between two requesters: M0 (boot loader/debug) and M1 (CPU load/store).
- Round-robin arbitration.
- Optional lock lets a requester hold the port for back-to-back bursts, bounded by a timeout.
- Tracks the memory's 1-cycle read latency and returns read data with a valid strobe to the requester that issued the read.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter: FSM states,
// requester IDs and a helper mapping a requester ID to its lock state.
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_ARB   = 2'd0;
  localparam arb_state_t ST_LOCK0 = 2'd1;
  localparam arb_state_t ST_LOCK1 = 2'd2;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  function automatic arb_state_t lock_state_of(input logic id);
    return (id == ID_M1) ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester that
// did not win last time is granted.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_winner == ID_M0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between M0 and M1 with round-robin arbitration,
// bounded lock bursts, and 1-cycle read-return routing to the issuing requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_LOCK = 16,
  parameter int LOCK_W   = 5
) (
  input  logic         clk,
  input  logic         rstb,

  input  logic         m0_req,
  input  logic         m0_we,
  input  logic         m0_lock,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [N-1:0] m0_rdata,

  input  logic         m1_req,
  input  logic         m1_we,
  input  logic         m1_lock,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [N-1:0] m1_rdata,

  output logic         mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout
);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  arb_state_t        state_q, state_d;
  logic              last_winner_q, last_winner_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              rd_pending_q, rd_pending_d;
  logic              rd_owner_q, rd_owner_d;

  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       any_gnt;
  logic       sel_we;
  logic       sel_lock;

  rr_arb2 u_rr_arb2 (
    .req         ({m1_req, m0_req}),
    .last_winner (last_winner_q),
    .gnt         (arb_gnt)
  );

  // A locked owner is the only candidate; reset blocks every issue.
  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ST_LOCK0: gnt = {1'b0, m0_req};
      ST_LOCK1: gnt = {m1_req, 1'b0};
      default:  gnt = arb_gnt;
    endcase
    if (rstb) gnt = 2'b00;
  end

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign any_gnt  = |gnt;
  assign gnt_id   = gnt[1];
  assign sel_we   = gnt_id ? m1_we   : m0_we;
  assign sel_lock = gnt_id ? m1_lock : m0_lock;

  assign mem_wr_ena = any_gnt & sel_we;
  assign mem_addr   = gnt[1] ? m1_addr  : m0_addr;
  assign mem_din    = gnt[1] ? m1_wdata : m0_wdata;

  assign m0_rvalid = rd_pending_q & (rd_owner_q == ID_M0) & ~rstb;
  assign m1_rvalid = rd_pending_q & (rd_owner_q == ID_M1) & ~rstb;
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;
    rd_pending_d  = any_gnt & ~sel_we;
    rd_owner_d    = gnt_id;

    unique case (state_q)
      ST_LOCK0, ST_LOCK1: begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        // Release or timeout: the owner is recorded as last winner so the
        // other side wins the next contested cycle in ARB.
        if (((state_q == ST_LOCK0) ? !m0_lock : !m1_lock) || (lock_cnt_q == LOCK_LAST)) begin
          state_d       = ST_ARB;
          lock_cnt_d    = '0;
          last_winner_d = (state_q == ST_LOCK1) ? ID_M1 : ID_M0;
        end
      end
      default: begin
        state_d = ST_ARB;
        if (any_gnt) begin
          last_winner_d = gnt_id;
          if (sel_lock) begin
            state_d    = lock_state_of(gnt_id);
            lock_cnt_d = LOCK_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q       <= ST_ARB;
      last_winner_q <= ID_M1;
      lock_cnt_q    <= '0;
      rd_pending_q  <= 1'b0;
      rd_owner_q    <= ID_M0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
      rd_pending_q  <= rd_pending_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small 1-cycle-latency memory model;
// unwritten words read back as 0xA0000000 | byte address.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rstb;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_wr_ena;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic [31:0] mem_arr [0:63];
  logic [63:0] written;

  int checks;
  int errors;

  mem_port_arbiter #(.N(32), .MAX_LOCK(16), .LOCK_W(5)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_lock    (m0_lock),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_lock    (m1_lock),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .mem_wr_ena (mem_wr_ena),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rstb) begin
      written <= '0;
    end else if (mem_wr_ena) begin
      mem_arr[mem_addr[7:2]] <= mem_din;
      written[mem_addr[7:2]] <= 1'b1;
    end
    mem_dout <= written[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : (32'hA000_0000 | mem_addr);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic l0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic l1,
                               input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkGnt(input string tag, input logic e0, input logic e1);
    checkOutput({tag, "_m0_gnt"}, 32'(m0_gnt), 32'(e0));
    checkOutput({tag, "_m1_gnt"}, 32'(m1_gnt), 32'(e1));
  endtask

  task automatic checkRv(input string tag, input logic e0, input logic e1);
    checkOutput({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'(e0));
    checkOutput({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'(e1));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstb   = 1'b1;
    idle();
    repeat (2) nextCycle();

    // Requests during reset must not issue.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h55, 1'b1, 1'b1, 1'b0, 32'h24, 32'h66);
    checkGnt("rst", 1'b0, 1'b0);
    checkOutput("rst_wr_ena", 32'(mem_wr_ena), 32'h0);
    checkRv("rst", 1'b0, 1'b0);

    // Contest after reset: M0, M1, M0, M1 with reads returning a cycle later.
    nextCycle();
    rstb = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("c1", 1'b1, 1'b0);
    checkOutput("c1_addr", mem_addr, 32'h0);
    checkOutput("c1_wr_ena", 32'(mem_wr_ena), 32'h0);
    checkRv("c1", 1'b0, 1'b0);

    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("c2", 1'b0, 1'b1);
    checkOutput("c2_addr", mem_addr, 32'h4);
    checkRv("c2", 1'b1, 1'b0);
    checkOutput("c2_m0_rdata", m0_rdata, 32'hA000_0000);

    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("c3", 1'b1, 1'b0);
    checkRv("c3", 1'b0, 1'b1);
    checkOutput("c3_m1_rdata", m1_rdata, 32'hA000_0004);

    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("c4", 1'b0, 1'b1);
    checkRv("c4", 1'b1, 1'b0);
    checkOutput("c4_m0_rdata", m0_rdata, 32'hA000_0000);

    nextCycle();
    idle();
    checkGnt("c5", 1'b0, 1'b0);
    checkRv("c5", 1'b0, 1'b1);
    checkOutput("c5_m1_rdata", m1_rdata, 32'hA000_0004);

    // M1 writes then reads back the same word.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checkGnt("wr", 1'b0, 1'b1);
    checkOutput("wr_wr_ena", 32'(mem_wr_ena), 32'h1);
    checkOutput("wr_addr", mem_addr, 32'h10);
    checkOutput("wr_din", mem_din, 32'hDEAD_BEEF);

    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    checkGnt("rd", 1'b0, 1'b1);
    checkOutput("rd_wr_ena", 32'(mem_wr_ena), 32'h0);
    checkRv("rd_after_wr", 1'b0, 1'b0);

    nextCycle();
    idle();
    checkRv("rd_ret", 1'b0, 1'b1);
    checkOutput("rd_ret_m1_rdata", m1_rdata, 32'hDEAD_BEEF);

    // Lock release: four M0 grants, one empty LOCK0 exit cycle, then M1.
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      checkGnt("lk_rel_m0", 1'b1, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("lk_rel_exit", 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("lk_rel_m1", 1'b0, 1'b1);
    nextCycle();
    idle();

    // Lock timeout: 16 M0 grants, then M1, then M0 re-locks.
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      checkGnt("to_m0", 1'b1, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("to_m1", 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("to_relock", 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("to_locked", 1'b1, 1'b0);
    nextCycle();
    idle();
    checkGnt("to_exit", 1'b0, 1'b0);
    nextCycle();
    idle();

    // Reset while M1 holds the lock with a read just issued.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    checkGnt("lk1_enter", 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    checkGnt("lk1_hold", 1'b0, 1'b1);
    nextCycle();
    rstb = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h55, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    checkGnt("rst_mid", 1'b0, 1'b0);
    checkOutput("rst_mid_wr_ena", 32'(mem_wr_ena), 32'h0);
    checkRv("rst_mid", 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h55, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    checkGnt("rst_mid2", 1'b0, 1'b0);
    checkRv("rst_mid2", 1'b0, 1'b0);
    nextCycle();
    rstb = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("post_rst", 1'b1, 1'b0);
    checkRv("post_rst", 1'b0, 1'b0);
    nextCycle();
    idle();
    checkRv("post_rst_ret", 1'b1, 1'b0);
    checkOutput("post_rst_m0_rdata", m0_rdata, 32'hA000_0000);

    // Idle stretch, then a contest proves the FSM sat in ARB.
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      idle();
      checkGnt("idle", 1'b0, 1'b0);
      checkOutput("idle_wr_ena", 32'(mem_wr_ena), 32'h0);
      checkRv("idle", 1'b0, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    checkGnt("idle_arb", 1'b0, 1'b1);
    nextCycle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
